// File: rtl/monobit_stim_gen.sv
// monobit_stim_gen
// Self-test stimulus generator for monobit_core. It streams a BLOCK_LEN-bit
// test block to the core one bit per consumption handshake. It then waits for
// the core's verdict and compares that verdict with its own reference monobit
// decision, which it computes from the bits it actually sent.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start, mode[1:0]    : start pulse (honoured in IDLE/DONE) and stream type
//                         00 LFSR, 01 all-ones, 10 alternating, 11 biased
//   epsilon_rsc_dat     : current stream bit to the core (0 outside SEND)
//   epsilon_triosy_lz   : core consumed the current bit this cycle
//   valid_rsc_dat       : core verdict valid
//   is_random_rsc_dat   : core verdict
//   busy / done         : run in progress / run finished
//   pass                : captured core verdict
//   expect_random       : reference verdict
//   mismatch            : pass differs from expect_random
//   timeout             : the core's verdict never arrived
//   ones_count          : ones sent in the current or last block
module monobit_stim_gen #(
    parameter int unsigned BLOCK_LEN = 128,
    parameter int unsigned THRESH    = 29,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     mode,
    output logic                           epsilon_rsc_dat,
    input  logic                           epsilon_triosy_lz,
    input  logic                           valid_rsc_dat,
    input  logic                           is_random_rsc_dat,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           expect_random,
    output logic                           mismatch,
    output logic                           timeout,
    output logic [$clog2(BLOCK_LEN+1)-1:0] ones_count
);

    localparam int CW = $clog2(BLOCK_LEN + 1);
    localparam int SW = CW + 2;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [CW-1:0]   sent_cnt_q, sent_cnt_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            pass_q, pass_d;
    logic            expect_q, expect_d;
    logic            mismatch_q, mismatch_d;
    logic            timeout_q, timeout_d;
    logic            bit_src;

    // Galois form, shifting right: the feedback bit leaving at [0] is XORed
    // into the tap positions.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    // Reference monobit test: S = 2*ones - BLOCK_LEN, random when |S| <= THRESH.
    // The widened signed form keeps S and -S representable.
    function automatic logic ref_random(input logic [CW-1:0] ones);
        logic signed [SW-1:0] s;
        s = $signed({1'b0, ones, 1'b0}) - $signed(SW'(BLOCK_LEN));
        if (s < 0) begin
            s = -s;
        end
        return (s <= $signed(SW'(THRESH)));
    endfunction

    // The bit is taken from registered state only, so it holds steady through
    // any number of stall cycles.
    always_comb begin
        bit_src = 1'b0;
        if (state_q == S_SEND) begin
            case (mode_q)
                2'b00:   bit_src = lfsr_q[0];
                2'b01:   bit_src = 1'b1;
                2'b10:   bit_src = ~sent_cnt_q[0];
                default: bit_src = lfsr_q[0] & lfsr_q[1];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        sent_cnt_d = sent_cnt_q;
        ones_d     = ones_q;
        wait_cnt_d = wait_cnt_q;
        pass_d     = pass_q;
        expect_d   = expect_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_SEND;
                    mode_d     = mode;
                    sent_cnt_d = '0;
                    ones_d     = '0;
                    pass_d     = 1'b0;
                    expect_d   = 1'b0;
                    mismatch_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (epsilon_triosy_lz) begin
                    ones_d     = ones_q + {{(CW-1){1'b0}}, bit_src};
                    sent_cnt_d = sent_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    lfsr_d     = lfsr_step(lfsr_q);
                    // The final accept already includes its own bit in ones_d,
                    // so the reference verdict is ready on WAIT entry.
                    if (sent_cnt_q == CW'(BLOCK_LEN - 1)) begin
                        state_d    = S_WAIT;
                        expect_d   = ref_random(ones_d);
                        wait_cnt_d = '0;
                    end
                end
            end
            S_WAIT: begin
                // A verdict arriving on the expiry cycle still counts.
                if (valid_rsc_dat) begin
                    pass_d     = is_random_rsc_dat;
                    mismatch_d = is_random_rsc_dat ^ expect_q;
                    state_d    = S_DONE;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    mismatch_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            lfsr_q     <= SEED;
            sent_cnt_q <= '0;
            ones_q     <= '0;
            wait_cnt_q <= '0;
            pass_q     <= 1'b0;
            expect_q   <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lfsr_q     <= lfsr_d;
            sent_cnt_q <= sent_cnt_d;
            ones_q     <= ones_d;
            wait_cnt_q <= wait_cnt_d;
            pass_q     <= pass_d;
            expect_q   <= expect_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign epsilon_rsc_dat = bit_src;
    assign busy            = (state_q == S_SEND) || (state_q == S_WAIT);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign expect_random   = expect_q;
    assign mismatch        = mismatch_q;
    assign timeout         = timeout_q;
    assign ones_count      = ones_q;

endmodule

// File: tb/tb_monobit_stim_gen.sv
module tb_monobit_stim_gen;

    localparam int          BLOCK_LEN = 128;
    localparam int          THRESH    = 29;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          TIMEOUT   = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       eps;
    logic       triosy = 1'b0;
    logic       valid = 1'b0;
    logic       isr = 1'b0;
    logic       busy, done, pass, exp_r, mism, tmo;
    logic [7:0] ones;

    always #5 clk = ~clk;

    monobit_stim_gen #(
        .BLOCK_LEN(BLOCK_LEN),
        .THRESH(THRESH),
        .SEED(SEED),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .epsilon_rsc_dat(eps),
        .epsilon_triosy_lz(triosy),
        .valid_rsc_dat(valid),
        .is_random_rsc_dat(isr),
        .busy(busy),
        .done(done),
        .pass(pass),
        .expect_random(exp_r),
        .mismatch(mism),
        .timeout(tmo),
        .ones_count(ones)
    );

    typedef struct {
        int ones;
        bit er;
        bit ps;
        bit mm;
        bit to;
    } res_t;

    res_t        resq[$];
    bit          bitq[$];
    int          errors = 0;
    int          checks = 0;
    bit          sending = 1'b0;
    logic [15:0] m_lfsr = SEED;
    int          m_ones = 0;
    logic        done_prev = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b, want %b", nm, act, expv);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, expv);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit ref_exp(input int n1);
        int s;
        s = 2 * n1 - BLOCK_LEN;
        if (s < 0) s = -s;
        return s <= THRESH;
    endfunction

    function automatic bit model_bit(input logic [1:0] md, input int cnt, input logic [15:0] l);
        case (md)
            2'b00:   return l[0];
            2'b01:   return 1'b1;
            2'b10:   return (cnt % 2) == 0;
            default: return l[0] & l[1];
        endcase
    endfunction

    // Monitor: stream bits against the expected-bit queue, and finished runs
    // against the result queue.
    always @(negedge clk) begin
        if (sending && bitq.size() > 0) begin
            chk1(triosy ? "bit_accept" : "bit_hold", eps, bitq[0]);
            if (triosy) void'(bitq.pop_front());
        end
        if (done && !done_prev) begin
            if (resq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: done rose with ones=%0d, no run queued", ones);
            end else begin
                res_t r;
                r = resq.pop_front();
                chkn("res_ones", int'(ones), r.ones);
                chk1("res_expect", exp_r, r.er);
                chk1("res_pass", pass, r.ps);
                chk1("res_mismatch", mism, r.mm);
                chk1("res_timeout", tmo, r.to);
            end
        end
        done_prev <= done;
    end

    task automatic check_idle_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_pass"}, pass, 1'b0);
        chk1({tag, "_expect"}, exp_r, 1'b0);
        chk1({tag, "_mismatch"}, mism, 1'b0);
        chk1({tag, "_timeout"}, tmo, 1'b0);
        chkn({tag, "_ones"}, int'(ones), 0);
        chk1({tag, "_eps"}, eps, 1'b0);
    endtask

    task automatic do_start(input logic [1:0] md);
        mode  = md;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        mode   = ~md;          // the run must keep the latched mode
        m_ones = 0;
        chk1("start_busy", busy, 1'b1);
        chk1("start_done", done, 1'b0);
        chk1("start_timeout", tmo, 1'b0);
        chk1("start_expect", exp_r, 1'b0);
        chk1("start_pass", pass, 1'b0);
        chk1("start_mismatch", mism, 1'b0);
        chkn("start_ones", int'(ones), 0);
    endtask

    // force_n >= 0: the DUT LFSR is pinned to 1 for the first force_n bits
    // and to 0 afterwards (mode 00), so the block has exactly force_n ones.
    task automatic send_block(input logic [1:0] md, input int n, input bit stall,
                              input int force_n, input int pulse_at);
        int cnt;
        int cyc;
        bit pushed;
        bit b;
        cnt    = 0;
        cyc    = 0;
        pushed = 1'b0;
        b      = 1'b0;
        sending = 1'b1;
        while (cnt < n) begin
            if (!pushed) begin
                if (force_n >= 0) begin
                    if (cnt < force_n) force dut.lfsr_q = 16'h0001;
                    else               force dut.lfsr_q = 16'h0000;
                    b = (cnt < force_n);
                end else begin
                    b = model_bit(md, cnt, m_lfsr);
                end
                bitq.push_back(b);
                pushed = 1'b1;
            end
            triosy = stall ? cyc[0] : 1'b1;
            start  = (cyc == pulse_at);
            @(posedge clk); #1;
            if (triosy) begin
                m_ones += int'(b);
                if (force_n < 0) m_lfsr = m_step(m_lfsr);
                cnt++;
                pushed = 1'b0;
            end
            cyc++;
        end
        triosy  = 1'b0;
        start   = 1'b0;
        sending = 1'b0;
    endtask

    task automatic respond(input int d, input bit isr_v);
        repeat (d - 1) begin
            @(posedge clk); #1;
        end
        valid = 1'b1;
        isr   = isr_v;
        @(posedge clk); #1;
        valid = 1'b0;
        isr   = 1'b0;
        chk1("done_latency", done, 1'b1);
    endtask

    task automatic full_run(input logic [1:0] md, input bit stall, input int force_n,
                            input int pulse_at, input int d, input bit isr_v);
        res_t r;
        do_start(md);
        send_block(md, BLOCK_LEN, stall, force_n, pulse_at);
        if (force_n >= 0) release dut.lfsr_q;
        r.ones = m_ones;
        r.er   = ref_exp(m_ones);
        r.ps   = isr_v;
        r.mm   = isr_v ^ r.er;
        r.to   = 1'b0;
        resq.push_back(r);
        chk1("wait_busy", busy, 1'b1);
        chk1("wait_expect", exp_r, r.er);
        respond(d, isr_v);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        start = 1'b1;          // reset must win over start
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst    = 1'b0;
        start  = 1'b0;
        m_lfsr = SEED;
        bitq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   n;
        @(posedge clk); #1;
        reset_dut();
        check_idle_zero("reset");

        // All-ones: S = 128, not random; core agrees.
        full_run(2'b01, 1'b0, -1, -1, 3, 1'b0);
        // Alternating: 64 ones, random; core disagrees.
        full_run(2'b10, 1'b0, -1, -1, 1, 1'b0);
        // LFSR with stalls on every other cycle.
        full_run(2'b00, 1'b1, -1, -1, 2, 1'b1);

        // Timeout: no verdict at all.
        do_start(2'b01);
        send_block(2'b01, BLOCK_LEN, 1'b0, -1, -1);
        r.ones = 128; r.er = 1'b0; r.ps = 1'b0; r.mm = 1'b0; r.to = 1'b1;
        resq.push_back(r);
        n = 0;
        while (!done && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        chkn("timeout_cycles", n, TIMEOUT);
        chk1("timeout_flag", tmo, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Verdict arrives on the expiry cycle: verdict wins.
        full_run(2'b10, 1'b0, -1, -1, TIMEOUT, 1'b1);

        // Threshold boundaries with the LFSR pinned.
        full_run(2'b00, 1'b0, 50, -1, 1, 1'b1);
        full_run(2'b00, 1'b0, 78, -1, 1, 1'b1);
        full_run(2'b00, 1'b0, 49, -1, 1, 1'b1);
        full_run(2'b00, 1'b0, 79, -1, 1, 1'b1);

        // Reset mid-run, then a fresh biased block from SEED with an ignored
        // start pulse during SEND.
        reset_dut();
        do_start(2'b00);
        send_block(2'b00, 60, 1'b0, -1, -1);
        chkn("partial_ones", int'(ones), m_ones);
        reset_dut();
        check_idle_zero("midrun_reset");
        full_run(2'b11, 1'b0, -1, 20, 2, 1'b1);

        chkn("results_drained", resq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
